// File: rtl/my_mux_rr_n_way.sv
// N-way round-robin arbitrating mux with a single registered valid/ready output stage.
// Optional packet locking (in_last/out_last) is compiled in when MY_MUX_LOCK_EN is defined.
module my_mux_rr_n_way #(
  parameter int N     = 4,
  parameter int WIDTH = 16,
  localparam int SEL_W = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
`ifdef MY_MUX_LOCK_EN
  input  logic [N-1:0]       in_last,
  output logic               out_last,
`endif
  output logic [N-1:0]       in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SEL_W-1:0]   out_sel
);

  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] ptr_next;
  logic [N-1:0]     req;
  logic [SEL_W-1:0] grant;
  logic             grant_valid;
  logic             stage_free;
  logic             accept;

`ifdef MY_MUX_LOCK_EN
  logic             locked;
  logic [SEL_W-1:0] lock_ch;
`endif

  // While locked to a packet, only the owning channel may request.
  always_comb begin
    req = in_valid;
`ifdef MY_MUX_LOCK_EN
    if (locked) begin
      req          = '0;
      req[lock_ch] = in_valid[lock_ch];
    end
`endif
  end

  // Rotating priority search starting at ptr; the wrap is explicit so a
  // non-power-of-two N never produces an index past N-1.
  always_comb begin
    int idx;
    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    idx         = 0;
    grant_valid = 1'b0;
    grant       = '0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!grant_valid && req[idx]) begin
        grant_valid = 1'b1;
        grant       = SEL_W'(idx);
      end
    end
  end

  // rst_n gates acceptance so no channel sees ready while the block is held in reset.
  assign stage_free = !out_valid || out_ready;
  assign accept     = grant_valid && stage_free && rst_n;
  assign ptr_next   = (grant == SEL_W'(N - 1)) ? '0 : grant + SEL_W'(1);

  always_comb begin
    in_ready = '0;
    if (accept) in_ready[grant] = 1'b1;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      ptr       <= '0;
`ifdef MY_MUX_LOCK_EN
      out_last  <= 1'b0;
      locked    <= 1'b0;
      lock_ch   <= '0;
`endif
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= in_data[int'(grant)*WIDTH +: WIDTH];
      out_sel   <= grant;
`ifdef MY_MUX_LOCK_EN
      out_last  <= in_last[grant];
      // Priority only moves on once the packet's final beat has been taken.
      if (in_last[grant]) begin
        locked <= 1'b0;
        ptr    <= ptr_next;
      end else begin
        locked  <= 1'b1;
        lock_ch <= grant;
      end
`else
      ptr       <= ptr_next;
`endif
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_my_mux_rr_n_way.sv
// Self-checking bench for my_mux_rr_n_way: a cycle model for the N=4 instance plus
// directed literal checks, and a small N=3 instance for the non-power-of-two wrap.
module tb_my_mux_rr_n_way;

  localparam int N = 4;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_ready;
  logic [W-1:0]   out_data;
  logic           out_valid;
  logic           out_ready;
  logic [1:0]     out_sel;

  logic [3*W-1:0] d3;
  logic [2:0]     v3;
  logic [2:0]     r3;
  logic [W-1:0]   od3;
  logic           ov3;
  logic           ordy3;
  logic [1:0]     os3;

`ifdef MY_MUX_LOCK_EN
  logic [N-1:0] in_last;
  logic         out_last;
  logic [2:0]   l3 = 3'b111;
  logic         ol3;
`endif

  my_mux_rr_n_way #(.N(N), .WIDTH(W)) u4 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
`ifdef MY_MUX_LOCK_EN
    .in_last(in_last), .out_last(out_last),
`endif
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_sel(out_sel)
  );

  my_mux_rr_n_way #(.N(3), .WIDTH(W)) u3 (
    .clk(clk), .rst_n(rst_n), .in_data(d3), .in_valid(v3),
`ifdef MY_MUX_LOCK_EN
    .in_last(l3), .out_last(ol3),
`endif
    .in_ready(r3), .out_data(od3), .out_valid(ov3),
    .out_ready(ordy3), .out_sel(os3)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: output stage contents, rotating pointer and lock owner.
  logic [W-1:0] m_data;
  logic [1:0]   m_sel;
  logic         m_valid;
  logic         m_last;
  int           m_ptr;
  bit           m_locked;
  int           m_lock_ch;

  function automatic bit m_is_last(input int c);
`ifdef MY_MUX_LOCK_EN
    return in_last[c];
`else
    return 1'b1;
`endif
  endfunction

  function automatic int m_grant();
    for (int k = 0; k < N; k++) begin
      int c = (m_ptr + k) % N;
      if (m_locked && c != m_lock_ch) continue;
      if (in_valid[c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] m_ready();
    logic [N-1:0] r = '0;
    int g = m_grant();
    if (!rst_n || g < 0 || (m_valid && !out_ready)) return r;
    r[g] = 1'b1;
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid   <= 1'b0;
      m_data    <= '0;
      m_sel     <= '0;
      m_last    <= 1'b0;
      m_ptr     <= 0;
      m_locked  <= 1'b0;
      m_lock_ch <= 0;
    end else if (m_grant() >= 0 && (!m_valid || out_ready)) begin
      m_valid <= 1'b1;
      m_data  <= in_data[m_grant()*W +: W];
      m_sel   <= 2'(m_grant());
      m_last  <= m_is_last(m_grant());
      if (m_is_last(m_grant())) begin
        m_locked <= 1'b0;
        m_ptr    <= (m_grant() + 1) % N;
      end else begin
        m_locked  <= 1'b1;
        m_lock_ch <= m_grant();
      end
    end else if (out_ready) begin
      m_valid <= 1'b0;
    end
  end

  always @(negedge clk) begin
    check("model in_ready", in_ready, m_ready());
    check("model out_valid", out_valid, m_valid);
    check("model out_data", out_data, m_data);
    check("model out_sel", out_sel, m_sel);
`ifdef MY_MUX_LOCK_EN
    check("model out_last", out_last, m_last);
`endif
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] word(input int c);
    return in_data[c*W +: W];
  endfunction

  int exp_sel[5] = '{3, 0, 1, 2, 3};

  initial begin
    in_valid  = '0;
    in_data   = {16'h0008, 16'h0080, 16'h0800, 16'h8000};
    out_ready = 1'b1;
    v3        = '0;
    d3        = {16'h0333, 16'h0222, 16'h0111};
    ordy3     = 1'b1;
`ifdef MY_MUX_LOCK_EN
    in_last   = '1;
`endif

    #1 rst_n = 1'b0;
    #1;
    check("reset out_valid", out_valid, 1'b0);
    check("reset out_data", out_data, 16'h0000);
    check("reset out_sel", out_sel, 2'd0);
    in_valid = 4'b1111;
    #1 check("reset in_ready", in_ready, 4'b0000);
    step();
    step();
    rst_n = 1'b1;

    // Single channel after reset.
    in_valid = 4'b0100;
    #1 check("single in_ready", in_ready, 4'b0100);
    step();
    check("single out_valid", out_valid, 1'b1);
    check("single out_data", out_data, 16'h0080);
    check("single out_sel", out_sel, 2'd2);
    in_valid = 4'b1111;
    #1 check("ptr3 in_ready", in_ready, 4'b1000);

    // All channels valid: rotation starting from ptr=3.
    foreach (exp_sel[i]) begin
      step();
      check("rr out_sel", out_sel, exp_sel[i]);
      check("rr out_data", out_data, word(exp_sel[i]));
      check("rr in_ready onehot", $onehot(in_ready), 1'b1);
    end
    step();
    step();
    check("pre-bp out_data", out_data, 16'h0800);

    // Backpressure holds everything.
    out_ready = 1'b0;
    #1 check("bp in_ready", in_ready, 4'b0000);
    repeat (3) begin
      step();
      check("bp out_valid", out_valid, 1'b1);
      check("bp out_data", out_data, 16'h0800);
      check("bp out_sel", out_sel, 2'd1);
      check("bp in_ready", in_ready, 4'b0000);
    end
    out_ready = 1'b1;
    #1 check("bp release in_ready", in_ready, 4'b0100);
    step();
    check("bp release out_valid", out_valid, 1'b1);
    check("bp release out_sel", out_sel, 2'd2);
    check("bp release out_data", out_data, 16'h0080);

    // Asynchronous reset between edges while a word is held.
    #2 rst_n = 1'b0;
    #1;
    check("async rst out_valid", out_valid, 1'b0);
    check("async rst out_sel", out_sel, 2'd0);
    in_valid = 4'b1001;
    step();
    rst_n = 1'b1;
    #1 check("post-rst in_ready", in_ready, 4'b0001);
    step();
    check("post-rst out_sel", out_sel, 2'd0);
    check("post-rst out_data", out_data, 16'h8000);
    in_valid = 4'b0000;
    step();
    check("drain out_valid", out_valid, 1'b0);

`ifdef MY_MUX_LOCK_EN
    // ptr=1 here; ch1 sends a 3-beat packet while ch0 and ch2 stay valid.
    in_valid = 4'b0111;
    in_last  = 4'b1101;
    step();
    check("lock b1 out_sel", out_sel, 2'd1);
    check("lock b1 out_last", out_last, 1'b0);
    in_valid = 4'b0101;
    #1 check("lock gap in_ready", in_ready, 4'b0000);
    step();
    check("lock gap out_valid", out_valid, 1'b0);
    in_valid = 4'b0111;
    step();
    check("lock b2 out_sel", out_sel, 2'd1);
    check("lock b2 out_last", out_last, 1'b0);
    in_last = 4'b1111;
    step();
    check("lock b3 out_sel", out_sel, 2'd1);
    check("lock b3 out_last", out_last, 1'b1);
    step();
    check("lock after out_sel", out_sel, 2'd2);
    in_valid = 4'b0000;
    step();
`endif

    // N=3: reach ptr=2, then wrap to channel 0, then channel 1.
    v3 = 3'b010;
    step();
    check("n3 first out_sel", os3, 2'd1);
    v3 = 3'b011;
    #1 check("n3 wrap in_ready", r3, 3'b001);
    step();
    check("n3 wrap out_sel", os3, 2'd0);
    check("n3 wrap out_data", od3, 16'h0111);
    v3 = 3'b111;
    #1 check("n3 next in_ready", r3, 3'b010);
    step();
    check("n3 next out_sel", os3, 2'd1);
    check("n3 next out_data", od3, 16'h0222);
    check("n3 next out_valid", ov3, 1'b1);
    v3 = 3'b000;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
